ttt_move_sequencer: RTL and testbench
=====================================

// Module: ttt_move_sequencer
// PURPOSE
// - Game controller for the tic-tac-toe core: accepts single-cycle button pulses, moves a cursor
//   on the 3x3 board, validates and places marks, alternates X/O turns, scans for wins and
//   updates scores.
// - Sits between the button single-pulsers and the display/score logic; owns the board register.
// PARAMETERS
// - SCORE_W         12    width of P1s/P2s score counters (saturating)
// - TIMEOUT_CYCLES  1000  per-move cycle limit; used only with TTT_TIMEOUT_EN
// PORTS
// - Clk      in   1   single clock
// - reset    in   1   synchronous, active-high; clears all state including scores
// - Start    in   1   pulse: leave Qi, begin game
// - Ack      in   1   pulse: leave Qd, clear board for next game
// - BtnL/BtnR/BtnU/BtnD/BtnC  in  1 each  one-cycle pulses (pre-debounced)
// - board    out  18  cell k at [2k+1:2k]: 00 empty, 01 X, 10 O; k = row*3+col
// - pos      out  4   cursor cell 0..8
// - counter  out  4   marks placed this game, 0..9
// - Xwins, Owins  out  1  winner flags for current game
// - P1s, P2s out  SCORE_W  X / O cumulative wins
// - Qi, Qx, Qo, Qc, Qd  out  1  one-hot state
// - Illegal  out  1   one-cycle pulse: BtnC on occupied cell
// - Timeout  out  1   one-cycle pulse: move timer expired
// BEHAVIOUR
// - Reset: state Qi; board=0, pos=0, counter=0, Xwins=Owins=0, P1s=P2s=0, Illegal=Timeout=0.
//   Reset takes effect from any state, including mid-scan.
// - States:
//   - Qi -Start-> Qx.
//   - Qx/Qo: cursor moves or placement.
//   - Qc: win scan.
//   - Qd: game over; -Ack-> Qx, clears board/counter/pos/flags and keeps scores.
// - Cursor, Qx/Qo only; one action per cycle; priority C > L > R > U > D:
//   - L/R: col -/+ 1, wrapping within the row (col 0 -L-> col 2).
//   - U/D: row -/+ 1, wrapping within the column (row 0 -U-> row 2).
// - BtnC on empty cell:
//   - Write mover mark to board[pos] and counter+1 on the same edge; next state Qc.
//   - Remember the mover.
// - BtnC on occupied cell: Illegal=1 for one cycle; no write; stay in same state.
// - Qc: line index 0..7, one line per cycle.
//   - Order: rows 0-2, cols 0-2, diag 0-4-8, anti-diag 2-4-6.
//   - Match (all three cells = mover mark): set Xwins or Owins, increment P1s or P2s
//     (saturate at all-ones), -> Qd. Early exit.
//   - After line 7 with no match: counter==9 -> Qd (draw, both flags 0); else -> other
//     player's turn.
//   - Max latency from placing BtnC to next turn: 9 cycles.
// - Buttons ignored in Qi, Qc, Qd. Start ignored outside Qi; Ack ignored outside Qd.
// - Simultaneous Start+buttons in Qi: only Start acts.
// - X always moves first in every game.
// CONFIGURATION
// - TTT_TIMEOUT_EN defined:
//   - A move timer clears on entry to Qx/Qo and on any accepted button action.
//   - At TIMEOUT_CYCLES-1 it pulses Timeout and passes the turn (Qx<->Qo) with no mark placed.
//   - counter is unchanged.
// - TTT_TIMEOUT_EN undefined: no timer logic; Timeout tied 0; turns wait indefinitely.
// TESTING
// - Reset, Start, then BtnR x3 -> pos 0,1,2,0 (row wrap); BtnU from pos 0 -> pos 6.
// - X places cells 0,1,2; O places 3,4 (between X moves) -> Xwins=1, P1s=1, Qd within 2 cycles
//   of the final scan start; Ack -> board=0, counter=0, P1s still 1.
// - Play X:0,2,3,7,5 and O:1,4,6,8 -> counter=9, Qd, Xwins=Owins=0, scores unchanged.
// - BtnC on occupied cell 4 -> Illegal pulse 1 cycle, board and counter unchanged, same
//   player still to move.
// - Assert reset during Qc -> next cycle Qi, all outputs at reset values, P1s=P2s=0.
// - With TTT_TIMEOUT_EN and TIMEOUT_CYCLES=20: idle 20 cycles in Qx -> Timeout pulse, Qo,
//   counter 0.

Source files
------------

// File: rtl/ttt_move_sequencer_if.sv
// Button/handshake pulses into the tic-tac-toe move sequencer and board, score and state out of it.
interface ttt_move_sequencer_if #(
    parameter int SCORE_W = 12
);
    logic               Start;
    logic               Ack;
    logic               BtnL;
    logic               BtnR;
    logic               BtnU;
    logic               BtnD;
    logic               BtnC;
    logic [17:0]        board;
    logic [3:0]         pos;
    logic [3:0]         counter;
    logic               Xwins;
    logic               Owins;
    logic [SCORE_W-1:0] P1s;
    logic [SCORE_W-1:0] P2s;
    logic               Qi;
    logic               Qx;
    logic               Qo;
    logic               Qc;
    logic               Qd;
    logic               Illegal;
    logic               Timeout;

    modport master (
        output Start, Ack, BtnL, BtnR, BtnU, BtnD, BtnC,
        input  board, pos, counter, Xwins, Owins, P1s, P2s,
        input  Qi, Qx, Qo, Qc, Qd, Illegal, Timeout
    );

    modport slave (
        input  Start, Ack, BtnL, BtnR, BtnU, BtnD, BtnC,
        output board, pos, counter, Xwins, Owins, P1s, P2s,
        output Qi, Qx, Qo, Qc, Qd, Illegal, Timeout
    );
endinterface

// File: rtl/ttt_move_sequencer.sv
// Tic-tac-toe game controller: cursor, mark placement, X/O turns, serial win scan and scores.
// Optional per-move timer enabled by defining TTT_TIMEOUT_EN.
//
// state | meaning
// QI    | idle, waiting for Start
// QX    | X to move
// QO    | O to move
// QC    | scanning one line per cycle for a win by the last mover
// QD    | game over, waiting for Ack
module ttt_move_sequencer #(
    parameter int SCORE_W        = 12,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                 Clk,
    input  logic                 reset,
    ttt_move_sequencer_if.slave  bus
);
    typedef enum logic [4:0] {
        S_QI = 5'b00001,
        S_QX = 5'b00010,
        S_QO = 5'b00100,
        S_QC = 5'b01000,
        S_QD = 5'b10000
    } state_t;

    state_t             state, state_nx;
    logic [17:0]        board, board_nx;
    logic [3:0]         pos, pos_nx;
    logic [3:0]         counter, counter_nx;
    logic               mover, mover_nx;
    logic [2:0]         line, line_nx;
    logic               xwins, xwins_nx;
    logic               owins, owins_nx;
    logic [SCORE_W-1:0] p1s, p1s_nx;
    logic [SCORE_W-1:0] p2s, p2s_nx;
    logic               illegal, illegal_nx;
    logic [11:0]        cells;
    logic [1:0]         mark;

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] k);
        cell_at = b[{k, 1'b0} +: 2];
    endfunction

    // Cell indices {a,b,c} of scan line n: rows, columns, diagonal, anti-diagonal.
    function automatic logic [11:0] line_cells(input logic [2:0] n);
        case (n)
            3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
            3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
            3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
            3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
            3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
            3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
            3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
            default: line_cells = {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    function automatic logic [1:0] col_of(input logic [3:0] p);
        case (p)
            4'd0, 4'd3, 4'd6: col_of = 2'd0;
            4'd1, 4'd4, 4'd7: col_of = 2'd1;
            default:          col_of = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] row_of(input logic [3:0] p);
        if (p < 4'd3)      row_of = 2'd0;
        else if (p < 4'd6) row_of = 2'd1;
        else               row_of = 2'd2;
    endfunction

    logic cell_empty;
    logic in_turn;
    assign cell_empty = (cell_at(board, pos) == 2'b00);
    assign in_turn    = (state == S_QX) || (state == S_QO);

`ifdef TTT_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMR_W-1:0] tmr;
    logic             timeout, timeout_nx;
    logic             action;

    assign action = in_turn && ((bus.BtnC && cell_empty) ||
                                bus.BtnL || bus.BtnR || bus.BtnU || bus.BtnD);

    // Down-counter reloads on turn entry or accepted action; expiry is the zero compare.
    always_ff @(posedge Clk) begin
        if (reset) begin
            tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
        end else if (((state_nx == S_QX) || (state_nx == S_QO)) &&
                     ((state_nx != state) || action)) begin
            tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (reset) begin
            state   <= S_QI;
            board   <= '0;
            pos     <= '0;
            counter <= '0;
            mover   <= 1'b0;
            line    <= '0;
            xwins   <= 1'b0;
            owins   <= 1'b0;
            p1s     <= '0;
            p2s     <= '0;
            illegal <= 1'b0;
`ifdef TTT_TIMEOUT_EN
            timeout <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            board   <= board_nx;
            pos     <= pos_nx;
            counter <= counter_nx;
            mover   <= mover_nx;
            line    <= line_nx;
            xwins   <= xwins_nx;
            owins   <= owins_nx;
            p1s     <= p1s_nx;
            p2s     <= p2s_nx;
            illegal <= illegal_nx;
`ifdef TTT_TIMEOUT_EN
            timeout <= timeout_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        board_nx   = board;
        pos_nx     = pos;
        counter_nx = counter;
        mover_nx   = mover;
        line_nx    = line;
        xwins_nx   = xwins;
        owins_nx   = owins;
        p1s_nx     = p1s;
        p2s_nx     = p2s;
        illegal_nx = 1'b0;
`ifdef TTT_TIMEOUT_EN
        timeout_nx = 1'b0;
`endif
        cells = line_cells(line);
        mark  = mover ? 2'b10 : 2'b01;

        case (state)
            S_QI: begin
                if (bus.Start) state_nx = S_QX;
            end
            S_QX, S_QO: begin
                if (bus.BtnC) begin
                    if (cell_empty) begin
                        board_nx[{pos, 1'b0} +: 2] = (state == S_QO) ? 2'b10 : 2'b01;
                        counter_nx = counter + 4'd1;
                        mover_nx   = (state == S_QO);
                        line_nx    = '0;
                        state_nx   = S_QC;
                    end else begin
                        illegal_nx = 1'b1;
                    end
                end else if (bus.BtnL) begin
                    pos_nx = (col_of(pos) == 2'd0) ? pos + 4'd2 : pos - 4'd1;
                end else if (bus.BtnR) begin
                    pos_nx = (col_of(pos) == 2'd2) ? pos - 4'd2 : pos + 4'd1;
                end else if (bus.BtnU) begin
                    pos_nx = (row_of(pos) == 2'd0) ? pos + 4'd6 : pos - 4'd3;
                end else if (bus.BtnD) begin
                    pos_nx = (row_of(pos) == 2'd2) ? pos - 4'd6 : pos + 4'd3;
                end
`ifdef TTT_TIMEOUT_EN
                else if (tmr == '0) begin
                    timeout_nx = 1'b1;
                    state_nx   = (state == S_QX) ? S_QO : S_QX;
                end
`endif
            end
            S_QC: begin
                if (cell_at(board, cells[11:8]) == mark &&
                    cell_at(board, cells[7:4])  == mark &&
                    cell_at(board, cells[3:0])  == mark) begin
                    state_nx = S_QD;
                    if (mover) begin
                        owins_nx = 1'b1;
                        if (p2s != '1) p2s_nx = p2s + 1'b1;
                    end else begin
                        xwins_nx = 1'b1;
                        if (p1s != '1) p1s_nx = p1s + 1'b1;
                    end
                end else if (line == 3'd7) begin
                    if (counter == 4'd9) state_nx = S_QD;
                    else                 state_nx = mover ? S_QX : S_QO;
                end else begin
                    line_nx = line + 3'd1;
                end
            end
            S_QD: begin
                if (bus.Ack) begin
                    state_nx   = S_QX;
                    board_nx   = '0;
                    counter_nx = '0;
                    pos_nx     = '0;
                    xwins_nx   = 1'b0;
                    owins_nx   = 1'b0;
                    mover_nx   = 1'b0;
                end
            end
            default: state_nx = S_QI;
        endcase
    end

    assign bus.board   = board;
    assign bus.pos     = pos;
    assign bus.counter = counter;
    assign bus.Xwins   = xwins;
    assign bus.Owins   = owins;
    assign bus.P1s     = p1s;
    assign bus.P2s     = p2s;
    assign bus.Qi      = state[0];
    assign bus.Qx      = state[1];
    assign bus.Qo      = state[2];
    assign bus.Qc      = state[3];
    assign bus.Qd      = state[4];
    assign bus.Illegal = illegal;
`ifdef TTT_TIMEOUT_EN
    assign bus.Timeout = timeout;
`else
    assign bus.Timeout = 1'b0;
`endif
endmodule

// File: tb/tb_ttt_move_sequencer.sv
// Directed bench for ttt_move_sequencer: cursor wrap, win, draw, illegal move, reset mid-scan, timer.
module tb_ttt_move_sequencer;
    localparam logic [6:0] P_START = 7'b1000000;
    localparam logic [6:0] P_ACK   = 7'b0100000;
    localparam logic [6:0] P_L     = 7'b0010000;
    localparam logic [6:0] P_R     = 7'b0001000;
    localparam logic [6:0] P_U     = 7'b0000100;
    localparam logic [6:0] P_D     = 7'b0000010;
    localparam logic [6:0] P_C     = 7'b0000001;

    localparam logic [4:0] ST_I = 5'b10000;
    localparam logic [4:0] ST_X = 5'b01000;
    localparam logic [4:0] ST_O = 5'b00100;
    localparam logic [4:0] ST_C = 5'b00010;
    localparam logic [4:0] ST_D = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [17:0] exp_board;
    int          exp_pos;
    int          exp_cnt;

    always #5 clk = ~clk;

    ttt_move_sequencer_if #(.SCORE_W(12)) bus ();

    ttt_move_sequencer #(.SCORE_W(12), .TIMEOUT_CYCLES(20)) dut (
        .Clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    function automatic logic [4:0] st();
        return {bus.Qi, bus.Qx, bus.Qo, bus.Qc, bus.Qd};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [6:0] v);
        {bus.Start, bus.Ack, bus.BtnL, bus.BtnR, bus.BtnU, bus.BtnD, bus.BtnC} = v;
        tick();
        {bus.Start, bus.Ack, bus.BtnL, bus.BtnR, bus.BtnU, bus.BtnD, bus.BtnC} = '0;
    endtask

    task automatic goto_cell(input int k);
        while (exp_pos % 3 != k % 3) begin
            press(P_R);
            exp_pos = (exp_pos % 3 == 2) ? exp_pos - 2 : exp_pos + 1;
        end
        while (exp_pos / 3 != k / 3) begin
            press(P_D);
            exp_pos = (exp_pos >= 6) ? exp_pos - 6 : exp_pos + 3;
        end
        check_val("goto_pos", 32'(bus.pos), 32'(k));
    endtask

    // Place a mark and wait out the scan; max_wait bounds cycles spent in Qc after the placing edge.
    task automatic place(input int k, input logic [1:0] m, input logic [4:0] st_after, input int max_wait);
        int n;
        goto_cell(k);
        press(P_C);
        exp_board[2*k +: 2] = m;
        exp_cnt++;
        check_val("place_board", 32'(bus.board), 32'(exp_board));
        check_val("place_cnt", 32'(bus.counter), 32'(exp_cnt));
        n = 0;
        while (st() == ST_C && n < 12) begin
            tick();
            n++;
        end
        check_val("scan_state", 32'(st()), 32'(st_after));
        check_val("scan_latency_ok", 32'(n <= max_wait), 32'd1);
    endtask

    initial begin
        int n;
        {bus.Start, bus.Ack, bus.BtnL, bus.BtnR, bus.BtnU, bus.BtnD, bus.BtnC} = '0;
        exp_board = '0;
        exp_pos   = 0;
        exp_cnt   = 0;
        tick();
        tick();
        rst = 1'b0;

        check_val("rst_state", 32'(st()), 32'(ST_I));
        check_val("rst_board", 32'(bus.board), 32'd0);
        check_val("rst_pos", 32'(bus.pos), 32'd0);
        check_val("rst_cnt", 32'(bus.counter), 32'd0);
        check_val("rst_flags", 32'({bus.Xwins, bus.Owins, bus.Illegal, bus.Timeout}), 32'd0);
        check_val("rst_scores", 32'({bus.P1s, bus.P2s}), 32'd0);

        press(P_R);
        check_val("qi_btn_ignored", 32'(bus.pos), 32'd0);
        press(P_START | P_R);
        check_val("start_state", 32'(st()), 32'(ST_X));
        check_val("start_only", 32'(bus.pos), 32'd0);

        press(P_R); check_val("r1", 32'(bus.pos), 32'd1);
        press(P_R); check_val("r2", 32'(bus.pos), 32'd2);
        press(P_R); check_val("r_wrap", 32'(bus.pos), 32'd0);
        press(P_U); check_val("u_wrap", 32'(bus.pos), 32'd6);
        press(P_D); check_val("d_wrap", 32'(bus.pos), 32'd0);
        press(P_L | P_R); check_val("l_over_r", 32'(bus.pos), 32'd2);
        press(P_U | P_D); check_val("u_over_d", 32'(bus.pos), 32'd8);
        press(P_L); check_val("l_step", 32'(bus.pos), 32'd7);
        press(P_START);
        check_val("start_ignored", 32'(st()), 32'(ST_X));
        exp_pos = 7;

        // Game 1: X takes row 0.
        place(0, 2'b01, ST_O, 8);
        place(3, 2'b10, ST_X, 8);
        place(1, 2'b01, ST_O, 8);
        place(4, 2'b10, ST_X, 8);
        place(2, 2'b01, ST_D, 2);
        check_val("g1_board", 32'(bus.board), 32'h00295);
        check_val("g1_xwins", 32'({bus.Xwins, bus.Owins}), 32'b10);
        check_val("g1_p1s", 32'(bus.P1s), 32'd1);
        check_val("g1_p2s", 32'(bus.P2s), 32'd0);
        press(P_R);
        check_val("qd_btn_ignored", 32'(bus.pos), 32'd2);
        press(P_START);
        check_val("qd_start_ignored", 32'(st()), 32'(ST_D));
        press(P_ACK);
        exp_board = '0; exp_pos = 0; exp_cnt = 0;
        check_val("ack_state", 32'(st()), 32'(ST_X));
        check_val("ack_board", 32'(bus.board), 32'd0);
        check_val("ack_cnt", 32'(bus.counter), 32'd0);
        check_val("ack_pos", 32'(bus.pos), 32'd0);
        check_val("ack_flags", 32'({bus.Xwins, bus.Owins}), 32'd0);
        check_val("ack_p1s", 32'(bus.P1s), 32'd1);

        // Game 2: draw, with an illegal attempt on cell 4.
        place(0, 2'b01, ST_O, 8);
        place(1, 2'b10, ST_X, 8);
        place(2, 2'b01, ST_O, 8);
        place(4, 2'b10, ST_X, 8);
        goto_cell(4);
        press(P_C);
        check_val("illegal_pulse", 32'(bus.Illegal), 32'd1);
        check_val("illegal_board", 32'(bus.board), 32'(exp_board));
        check_val("illegal_cnt", 32'(bus.counter), 32'd4);
        check_val("illegal_state", 32'(st()), 32'(ST_X));
        tick();
        check_val("illegal_1cyc", 32'(bus.Illegal), 32'd0);
        place(3, 2'b01, ST_O, 8);
        place(6, 2'b10, ST_X, 8);
        place(7, 2'b01, ST_O, 8);
        place(8, 2'b10, ST_X, 8);
        place(5, 2'b01, ST_D, 8);
        check_val("draw_cnt", 32'(bus.counter), 32'd9);
        check_val("draw_flags", 32'({bus.Xwins, bus.Owins}), 32'd0);
        check_val("draw_scores", 32'({bus.P1s, bus.P2s}), {20'd0, 12'd1, 12'd0} );
        press(P_ACK);
        exp_board = '0; exp_pos = 0; exp_cnt = 0;
        check_val("g3_x_first", 32'(st()), 32'(ST_X));

        // Reset in the middle of a scan.
        goto_cell(4);
        press(P_C);
        check_val("g3_in_scan", 32'(st()), 32'(ST_C));
        press(P_R);
        check_val("qc_btn_ignored", 32'(bus.pos), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_board = '0; exp_pos = 0; exp_cnt = 0;
        check_val("mrst_state", 32'(st()), 32'(ST_I));
        check_val("mrst_board", 32'(bus.board), 32'd0);
        check_val("mrst_pos_cnt", 32'({bus.pos, bus.counter}), 32'd0);
        check_val("mrst_scores", 32'({bus.P1s, bus.P2s}), 32'd0);
        check_val("mrst_flags", 32'({bus.Xwins, bus.Owins, bus.Illegal, bus.Timeout}), 32'd0);

        press(P_START);
`ifdef TTT_TIMEOUT_EN
        n = 0;
        while (!bus.Timeout && n < 40) begin
            tick();
            n++;
        end
        check_val("tmo_cycles", 32'(n), 32'd20);
        check_val("tmo_state", 32'(st()), 32'(ST_O));
        check_val("tmo_cnt", 32'(bus.counter), 32'd0);
        tick();
        check_val("tmo_1cyc", 32'(bus.Timeout), 32'd0);
`else
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.Timeout) n++;
        end
        check_val("no_tmo_pulse", 32'(n), 32'd0);
        check_val("no_tmo_state", 32'(st()), 32'(ST_X));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
